// File: rtl/fencei_seq_if.sv
// Interface between the fence.i sequencer and the pipeline, LSU and icache.
// The master side drives the fence request and the environment status.
interface fencei_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic             fencei_req;
  logic [31:0]      fencei_pc;
  logic             lsu_idle;
  logic             inv_ready;
  logic             inv_done;
  logic             err_clr;
  logic             busy;
  logic             flush;
  logic             inv_valid;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             drain_timeout;
  logic [CNT_W-1:0] fence_cnt;

  modport master (
    output fencei_req, fencei_pc, lsu_idle, inv_ready, inv_done, err_clr,
    input  busy, flush, inv_valid, redirect_valid, redirect_pc, drain_timeout, fence_cnt
  );

  modport slave (
    input  fencei_req, fencei_pc, lsu_idle, inv_ready, inv_done, err_clr,
    output busy, flush, inv_valid, redirect_valid, redirect_pc, drain_timeout, fence_cnt
  );
endinterface

// File: rtl/fencei_seq.sv
// fence.i sequencer: flush, drain the LSU (bounded), invalidate the icache, then
// redirect fetch to pc+4. Every output is decoded from registered state.
module fencei_seq #(
  parameter int unsigned DRAIN_MAX = 255,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  fencei_seq_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StInvReq,
    StInvWait,
    StRedirect
  } state_e;

  localparam logic [7:0] DrainLast = 8'(DRAIN_MAX - 1);

  state_e           state_q, state_d;
  logic [7:0]       drain_cnt_q, drain_cnt_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] fence_cnt_q, fence_cnt_d;
  logic             timeout_set;

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    redirect_pc_d = redirect_pc_q;
    fence_cnt_d   = fence_cnt_q;
    timeout_set   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.fencei_req) begin
          redirect_pc_d = bus.fencei_pc + 32'd4;
          drain_cnt_d   = '0;
          state_d       = StDrain;
        end
      end
      StDrain: begin
        if (bus.lsu_idle) begin
          state_d = StInvReq;
        end else if (drain_cnt_q == DrainLast) begin
          // LSU never went idle: give up waiting and record it
          timeout_set = 1'b1;
          state_d     = StInvReq;
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      StInvReq: begin
        if (bus.inv_ready) state_d = StInvWait;
      end
      StInvWait: begin
        if (bus.inv_done) state_d = StRedirect;
      end
      StRedirect: begin
        fence_cnt_d = fence_cnt_q + CNT_W'(1);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A timeout in the same cycle as err_clr keeps the flag set
    timeout_d = timeout_set | (timeout_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      drain_cnt_q   <= '0;
      redirect_pc_q <= '0;
      timeout_q     <= 1'b0;
      fence_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      redirect_pc_q <= redirect_pc_d;
      timeout_q     <= timeout_d;
      fence_cnt_q   <= fence_cnt_d;
    end
  end

  // The drain counter is zero only in the first DRAIN cycle, which is the flush cycle
  assign bus.busy           = (state_q != StIdle);
  assign bus.flush          = (state_q == StDrain) && (drain_cnt_q == 8'd0);
  assign bus.inv_valid      = (state_q == StInvReq);
  assign bus.redirect_valid = (state_q == StRedirect);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.drain_timeout  = timeout_q;
  assign bus.fence_cnt      = fence_cnt_q;

endmodule

// File: tb/tb_fencei_seq.sv
// Bench for fencei_seq: a timeline model derives per-cycle expected outputs from each
// scenario's parameters; literal checks pin latencies and key values.
module tb_fencei_seq;
  localparam int unsigned DrainMax = 8;
  localparam int unsigned CntW     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fencei_seq_if #(.CNT_W(CntW)) bus_if ();

  fencei_seq #(.DRAIN_MAX(DrainMax), .CNT_W(CntW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int rv_cyc = -1;
  int fl_cyc = -1;
  int iv_n = 0;
  bit chk_en = 1'b0;

  logic            m_busy, m_flush, m_inv_valid, m_rv, m_to, to_next;
  logic [31:0]     m_rpc;
  logic [CntW-1:0] m_cnt;
  bit              cnt_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process
  initial forever begin
    @(negedge clk);
    if (bus_if.redirect_valid === 1'b1) rv_cyc = cyc;
    if (bus_if.flush === 1'b1) fl_cyc = cyc;
    if (bus_if.inv_valid === 1'b1) iv_n++;
    if (chk_en) begin
      chk("busy", 32'(bus_if.busy), 32'(m_busy));
      chk("flush", 32'(bus_if.flush), 32'(m_flush));
      chk("inv_valid", 32'(bus_if.inv_valid), 32'(m_inv_valid));
      chk("redirect_valid", 32'(bus_if.redirect_valid), 32'(m_rv));
      chk("redirect_pc", bus_if.redirect_pc, m_rpc);
      chk("drain_timeout", 32'(bus_if.drain_timeout), 32'(m_to));
      chk("fence_cnt", 32'(bus_if.fence_cnt), 32'(m_cnt));
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    m_cnt       = m_cnt + CntW'(cnt_pend);
    cnt_pend    = 1'b0;
    m_to        = to_next;
    m_busy      = 1'b0;
    m_flush     = 1'b0;
    m_inv_valid = 1'b0;
    m_rv        = 1'b0;
  endtask

  task automatic idle(input int cycles, input bit clr, input bit stray);
    for (int i = 0; i < cycles; i++) begin
      begin_cycle();
      bus_if.fencei_req = 1'b0;
      bus_if.lsu_idle   = 1'b1;
      bus_if.inv_ready  = 1'b1;
      bus_if.inv_done   = stray;
      bus_if.err_clr    = clr;
      to_next = clr ? 1'b0 : m_to;
    end
  endtask

  // One fence: LSU busy for n drain cycles, inv_ready low r cycles, inv_done d cycles late.
  task automatic run_seq(input logic [31:0] pc, input int n, input int r, input int d,
                         input int clr_k, input bit extra, input int abort_k,
                         output int lat, output int flat, output int ivn);
    bit tmo;
    bit stop;
    int dlen, rk, xk, t0;
    tmo  = (n >= int'(DrainMax));
    dlen = tmo ? int'(DrainMax) : n + 1;
    rk   = 3 + dlen + r + d;
    xk   = extra ? 2 + dlen + r : -1;
    stop = 1'b0;
    lat  = -1;
    flat = -1;
    ivn  = -1;
    t0   = 0;
    for (int k = 0; k <= rk && !stop; k++) begin
      begin_cycle();
      if (k == 0) begin
        t0   = cyc;
        iv_n = 0;
      end
      m_busy      = (k >= 1);
      m_flush     = (k == 1);
      m_inv_valid = (k >= 1 + dlen) && (k <= 1 + dlen + r);
      m_rv        = (k == rk);
      if (k == 1) m_rpc = pc + 32'd4;
      bus_if.fencei_req = (k == 0) || (k == xk);
      bus_if.fencei_pc  = (k == 0) ? pc : ~pc;
      bus_if.lsu_idle   = !(k >= 1 && k <= n);
      bus_if.inv_ready  = !(k >= 1 + dlen && k < 1 + dlen + r);
      bus_if.inv_done   = (k == 2 + dlen + r + d);
      bus_if.err_clr    = (k == clr_k);
      if (k == 0 && rst_n == 1'b0) rst_n = 1'b1;
      to_next = (tmo && k == dlen) ? 1'b1 : (bus_if.err_clr ? 1'b0 : m_to);
      if (k == rk) begin
        cnt_pend = 1'b1;
        @(negedge clk);
        #1;
        lat  = rv_cyc - t0;
        flat = fl_cyc - t0;
        ivn  = iv_n;
      end
      if (k == abort_k) begin
        #2;
        rst_n = 1'b0;
        #1;
        m_busy = 1'b0; m_flush = 1'b0; m_inv_valid = 1'b0; m_rv = 1'b0;
        m_rpc = '0; m_cnt = '0; m_to = 1'b0; to_next = 1'b0; cnt_pend = 1'b0;
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        chk("abort_inv_valid", 32'(bus_if.inv_valid), 32'd0);
        chk("abort_redirect_valid", 32'(bus_if.redirect_valid), 32'd0);
        chk("abort_fence_cnt", 32'(bus_if.fence_cnt), 32'd0);
        chk("abort_redirect_pc", bus_if.redirect_pc, 32'd0);
        stop = 1'b1;
      end
    end
  endtask

  initial begin
    int lat, flat, ivn;
    bus_if.fencei_req = 1'b0;
    bus_if.fencei_pc  = '0;
    bus_if.lsu_idle   = 1'b1;
    bus_if.inv_ready  = 1'b1;
    bus_if.inv_done   = 1'b0;
    bus_if.err_clr    = 1'b0;
    m_busy = 1'b0; m_flush = 1'b0; m_inv_valid = 1'b0; m_rv = 1'b0;
    m_rpc = '0; m_cnt = '0; m_to = 1'b0; to_next = 1'b0; cnt_pend = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", 32'(bus_if.busy), 32'd0);
    chk("reset_flush", 32'(bus_if.flush), 32'd0);
    chk("reset_redirect_pc", bus_if.redirect_pc, 32'd0);
    chk("reset_fence_cnt", 32'(bus_if.fence_cnt), 32'd0);
    chk_en = 1'b1;

    // Fast path, accepted on the first edge after reset release
    run_seq(32'h8000_0100, 0, 0, 0, -1, 1'b0, -1, lat, flat, ivn);
    chk("fast_latency", lat, 32'd4);
    chk("fast_flush_at", flat, 32'd1);
    chk("fast_inv_cycles", ivn, 32'd1);
    idle(1, 1'b0, 1'b0);
    chk("fast_fence_cnt", 32'(bus_if.fence_cnt), 32'd1);
    chk("fast_redirect_pc", bus_if.redirect_pc, 32'h8000_0104);

    // Backpressure, then a back-to-back wrap fence with a second request in INV_WAIT
    run_seq(32'h0000_1000, 5, 3, 4, -1, 1'b0, -1, lat, flat, ivn);
    chk("bp_latency", lat, 32'd16);
    chk("bp_inv_cycles", ivn, 32'd4);
    run_seq(32'hFFFF_FFFC, 0, 0, 2, -1, 1'b1, -1, lat, flat, ivn);
    chk("wrap_latency", lat, 32'd6);
    idle(3, 1'b0, 1'b1);
    chk("wrap_redirect_pc", bus_if.redirect_pc, 32'h0000_0000);
    chk("wrap_fence_cnt", 32'(bus_if.fence_cnt), 32'd3);

    // Drain timeout, clear, then timeout coincident with err_clr
    run_seq(32'h0000_2000, 20, 0, 0, -1, 1'b0, -1, lat, flat, ivn);
    chk("tmo_latency", lat, 32'd11);
    idle(1, 1'b0, 1'b0);
    chk("tmo_flag_set", 32'(bus_if.drain_timeout), 32'd1);
    idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);
    chk("tmo_flag_cleared", 32'(bus_if.drain_timeout), 32'd0);
    run_seq(32'h0000_3000, 20, 0, 0, 8, 1'b0, -1, lat, flat, ivn);
    idle(1, 1'b0, 1'b0);
    chk("tmo_set_wins", 32'(bus_if.drain_timeout), 32'd1);

    // Reset during INV_WAIT, then a normal fence
    run_seq(32'h0000_4000, 0, 0, 5, -1, 1'b0, 5, lat, flat, ivn);
    run_seq(32'h0000_5000, 0, 0, 0, -1, 1'b0, -1, lat, flat, ivn);
    chk("post_reset_latency", lat, 32'd4);
    idle(2, 1'b0, 1'b0);
    chk("post_reset_fence_cnt", 32'(bus_if.fence_cnt), 32'd1);
    chk("post_reset_redirect_pc", bus_if.redirect_pc, 32'h0000_5004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", n_vec, n_bad);
    $fatal(1);
  end
endmodule
